// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO drained by an 8N1 serializer, sticky "TX drained" interrupt.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (11-bit frame).

// Byte FIFO; push refused while full, level tracks push - pop.
module uart_tx_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push_vld,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop_rdy,
  output logic [W-1:0]  o_pop_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);
  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full    = (r_level == (AW+1)'(2**AW));
  assign o_empty   = (r_level == '0);
  assign w_push    = i_push_vld && !o_full;
  assign w_pop     = i_pop_rdy && !o_empty;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
endmodule

module uart_tx_buffered #(
  parameter int CLK_FREQ        = 50000000,
  parameter int BAUD            = 115200,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               data_in,
  input  logic                     write_enable,
  output logic                     write_busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level,
  output logic                     tx_idle,
  output logic                     int_req,
  input  logic                     int_ack,
  output logic                     TxD
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] C_RELOAD = CW'(DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_int;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_fifo_dat;

  assign w_bit_end = (r_cnt == '0);
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));

  uart_tx_fifo #(.W(8), .AW(FIFO_DEPTH_LOG2)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (write_enable),
    .i_push_dat (data_in),
    .i_pop_rdy  (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= C_RELOAD;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_int   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      // TxD trails the state by one edge, so the first bit lasts DIV cycles like every other.
      case (r_state)
        S_START:  r_txd <= 1'b0;
        S_DATA:   r_txd <= r_shift[0];
`ifdef UART_TX_PARITY_EN
        S_PARITY: r_txd <= r_par;
`endif
        default:  r_txd <= 1'b1;
      endcase
      if (int_ack) r_int <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cnt <= C_RELOAD;
        if (w_pop) begin
          r_shift <= w_fifo_dat;
`ifdef UART_TX_PARITY_EN
          r_par   <= ^w_fifo_dat;
`endif
          r_state <= S_START;
        end
      end else if (!w_bit_end) begin
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_cnt <= C_RELOAD;
        case (r_state)
          S_START: begin
            r_bit   <= '0;
            r_state <= S_DATA;
          end
          S_DATA: begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (r_bit == 3'd7) r_state <= S_PARITY;
`else
            if (r_bit == 3'd7) r_state <= S_STOP;
`endif
          end
          S_PARITY: r_state <= S_STOP;
          default: begin
            if (w_pop) begin
              r_shift <= w_fifo_dat;
`ifdef UART_TX_PARITY_EN
              r_par   <= ^w_fifo_dat;
`endif
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
              r_int   <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign write_busy = w_full;
  assign tx_idle    = (r_state == S_IDLE) && (fifo_level == '0);
  assign int_req    = r_int;
  assign TxD        = r_txd;
endmodule
